jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//  Shares a bank of NBITS JK flip-flops among NREQ requesters. Each granted request drives one J/K pulse
//  onto a single bit, then reads back that bit's new Q. The block sits between client logic and the JK
//  bank, and all of them run on CLK. It is the only driver of the bank's J/K inputs.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  NBITS  8  number of JK flip-flops in the bank
//  IDXW   3  bit-index width; must satisfy 2**IDXW >= NBITS
// PORTS
//  CLK      in   1          clock; all state updates on the rising edge
//  RST_n    in   1          reset, asynchronous, active-low
//  REQ      in   NREQ       per-requester request; held high until GNT is seen
//  REQ_J    in   NREQ       per-requester J value
//  REQ_K    in   NREQ       per-requester K value
//  REQ_IDX  in   NREQ*IDXW  per-requester target bit; requester r uses [r*IDXW +: IDXW]
//  GNT      out  NREQ       one-hot grant, 1-cycle pulse
//  J_OUT    out  NBITS      J vector to the bank
//  K_OUT    out  NBITS      K vector to the bank
//  Q_IN     in   NBITS      Q vector from the bank
//  DONE     out  1          1-cycle pulse when an operation completes
//  DONE_ID  out  IDXW       requester index of the completed operation (low bits used)
//  RD_Q     out  1          post-operation Q of the target bit; valid while DONE=1
//  ERR      out  1          pulses with DONE when REQ_IDX >= NBITS
// BEHAVIOUR
//  Reset: all outputs are 0, FSM=IDLE, RR pointer=0. The reset is asynchronous, so J_OUT/K_OUT clear at once
//   and the bank holds its state.
//  FSM: IDLE -> APPLY -> SETTLE -> IDLE. Every state change happens on a CLK edge. All outputs are registered.
//  IDLE: on an edge with any REQ=1, the block picks a winner and latches sel, J, K, idx and the error flag. Next state is APPLY.
//   - Round robin: the search starts at the pointer and wraps at NREQ-1 -> 0.
//   - No REQ: the block stays in IDLE and all outputs are 0 (except DONE/RD_Q/ERR/DONE_ID, see SETTLE).
//  APPLY (1 cycle): GNT[sel]=1, J_OUT[idx]=J, K_OUT[idx]=K, all other J_OUT/K_OUT bits are 0.
//   - The bank samples J/K on the APPLY->SETTLE edge.
//   - Error case (idx >= NBITS): J_OUT=K_OUT=0 everywhere (no-op), but GNT is still issued.
//  SETTLE (1 cycle): GNT=0, J_OUT=K_OUT=0. On the exit edge:
//   - RD_Q <= Q_IN[idx] (0 if error), DONE <= 1, DONE_ID <= sel, ERR <= error flag;
//   - pointer <= (sel+1) mod NREQ.
//  DONE/RD_Q/ERR/DONE_ID are valid for the one IDLE cycle after SETTLE. DONE and ERR return to 0 the next
//   cycle. DONE_ID and RD_Q hold their values.
//  Latency: REQ seen at edge E0 -> GNT/J/K high during cycle E0..E1 -> DONE high during cycle E2..E3.
//  Throughput: one operation per 3 cycles. A new arbitration may occur on the same edge that drops DONE,
//   i.e. back-to-back with no idle cycle.
//  J/K semantics: 00 no-op (still granted and reported), 10 set, 01 clear, 11 toggle.
//  REQ changing during APPLY/SETTLE is ignored; only the latched operands are used.
//  Requester handshake: drop or change REQ no later than the cycle after GNT, otherwise it is re-arbitrated.
//  Simultaneous requests: exactly one GNT bit is ever set. A losing requester keeps REQ high and wins
//   within NREQ operations.
//  Reset mid-operation (APPLY/SETTLE): the operation is abandoned with no DONE, and the bank bit may or may
//   not have updated.
// CONFIGURATION
//  JK_ARB_PRIO0_EN defined: requester 0 has absolute priority. It wins whenever REQ[0]=1 in IDLE, and
//   round robin applies only among 1..NREQ-1. A grant to requester 0 does not move the pointer.
//  JK_ARB_PRIO0_EN undefined: pure round robin over all NREQ requesters.
// TESTING
//  1. Reset with RST_n=0 asserted mid-APPLY -> J_OUT=K_OUT=GNT=DONE=0 immediately; FSM IDLE; bank Q unchanged.
//  2. Set then toggle: REQ[1]=1, J=1, K=0, idx=5, Q_IN[5]=0 -> GNT=0010 in cycle 1, J_OUT=0x20 in cycle 1,
//     DONE, RD_Q=1, DONE_ID=1 in cycle 3. Repeat with J=K=1 -> RD_Q=0.
//  3. Contention: REQ=1111 held, each requester drops its REQ after its GNT -> grants 0,1,2,3 in order,
//     3 cycles apart, no GNT overlap. With JK_ARB_PRIO0_EN and REQ[0] reasserted every time -> 0 always wins.
//  4. Out of range: NBITS=6, REQ_IDX=7 -> GNT issued, J_OUT=K_OUT=0, DONE=1, ERR=1, RD_Q=0.
//  5. Back-to-back: REQ[2] asserted continuously -> GNT[2] every 3rd cycle, DONE on the cycle of the next
//     arbitration; pointer wraps correctly from 3 to 0.
//  6. No-op: J=K=0 -> GNT and DONE still pulse; Q_IN unchanged; RD_Q equals the prior Q.

Source files
------------

// File: rtl/jk_bank_arbiter_if.sv
// Requester, grant and JK-bank signal bundle for jk_bank_arbiter.
// The master side is the client/bank environment; the slave side is the arbiter.
interface jk_bank_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDXW  = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_j;
  logic [NREQ-1:0]      req_k;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      gnt;
  logic [NBITS-1:0]     j_out;
  logic [NBITS-1:0]     k_out;
  logic [NBITS-1:0]     q_in;
  logic                 done;
  logic [IDXW-1:0]      done_id;
  logic                 rd_q;
  logic                 err;

  modport master (
    output req, req_j, req_k, req_idx, q_in,
    input  gnt, j_out, k_out, done, done_id, rd_q, err
  );

  modport slave (
    input  req, req_j, req_k, req_idx, q_in,
    output gnt, j_out, k_out, done, done_id, rd_q, err
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that shares a JK flip-flop bank: one J/K pulse per grant, then Q read-back.
// Define JK_ARB_PRIO0_EN to give requester 0 absolute priority over the round robin.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic              CLK,
  input  logic              RST_n,
  jk_bank_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;

  state_t           state, state_d;
  logic [PW-1:0]    ptr, ptr_d;
  logic [PW-1:0]    sel, sel_d;
  logic [IDXW-1:0]  idx, idx_d;
  logic             oor, oor_d;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NBITS-1:0] j_q, j_d;
  logic [NBITS-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic [IDXW-1:0]  done_id_q, done_id_d;
  logic             rd_q_q, rd_q_d;
  logic             err_q, err_d;

  logic             found;
  logic [PW-1:0]    win;
  int unsigned      cand;
  logic [IDXW-1:0]  widx;
  logic             wj, wk, wbad;

  // Winner search: first asserted request starting at the pointer, wrapping to 0
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
`ifdef JK_ARB_PRIO0_EN
    if (bus.req[0]) begin
      found = 1'b1;
    end else
`endif
    begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cand = (32'(ptr) + i) % NREQ;
        if (!found && bus.req[cand]) begin
          found = 1'b1;
          win   = PW'(cand);
        end
      end
    end
  end

  assign widx = bus.req_idx[32'(win)*IDXW +: IDXW];
  assign wj   = bus.req_j[win];
  assign wk   = bus.req_k[win];
  assign wbad = !(32'(widx) < NBITS);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    sel_d     = sel;
    idx_d     = idx;
    oor_d     = oor;
    gnt_d     = '0;
    j_d       = '0;
    k_d       = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    done_id_d = done_id_q;
    rd_q_d    = rd_q_q;

    case (state)
      IDLE: begin
        if (found) begin
          sel_d      = win;
          idx_d      = widx;
          oor_d      = wbad;
          gnt_d[win] = 1'b1;
          for (int unsigned b = 0; b < NBITS; b++) begin
            j_d[b] = wj && !wbad && (32'(widx) == b);
            k_d[b] = wk && !wbad && (32'(widx) == b);
          end
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        done_d    = 1'b1;
        done_id_d = IDXW'(sel);
        err_d     = oor;
        rd_q_d    = 1'b0;
        for (int unsigned b = 0; b < NBITS; b++) begin
          if (!oor && (32'(idx) == b)) rd_q_d = bus.q_in[b];
        end
        ptr_d = (32'(sel) == NREQ - 1) ? '0 : PW'(32'(sel) + 1);
`ifdef JK_ARB_PRIO0_EN
        if (sel == '0) ptr_d = ptr;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; async clear drops J/K to the bank immediately
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      idx       <= '0;
      oor       <= 1'b0;
      gnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rd_q_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      sel       <= sel_d;
      idx       <= idx_d;
      oor       <= oor_d;
      gnt_q     <= gnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      rd_q_q    <= rd_q_d;
      err_q     <= err_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.j_out   = j_q;
  assign bus.k_out   = k_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.rd_q    = rd_q_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter (NREQ=4, NBITS=6, IDXW=3) driving a behavioural JK bank.
// Define JK_ARB_PRIO0_EN to also run the requester-0 priority scenario.
module tb_jk_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned NBITS = 6;
  localparam int unsigned IDXW  = 3;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [NBITS-1:0] j;
    logic [NBITS-1:0] k;
    int               gap;
  } gexp_t;

  typedef struct {
    logic [IDXW-1:0] id;
    logic            rd;
    logic            err;
  } dexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NBITS-1:0] bank = '0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  gexp_t gq[$];
  dexp_t dq[$];

  jk_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW)) bus ();

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural JK bank, not reset by the arbiter reset
  always @(posedge clk) begin
    for (int b = 0; b < int'(NBITS); b++) begin
      case ({bus.j_out[b], bus.k_out[b]})
        2'b10:   bank[b] <= 1'b1;
        2'b01:   bank[b] <= 1'b0;
        2'b11:   bank[b] <= ~bank[b];
        default: bank[b] <= bank[b];
      endcase
    end
  end
  assign bus.q_in = bank;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Expected model of one operation: grant pattern, J/K pulse, read-back
  task automatic expect_op(input int r, input bit j, input bit k, input int idx,
                           input int gap, input bit rd);
    gexp_t g;
    dexp_t d;
    bit bad;
    bad   = (idx >= int'(NBITS));
    g.gnt = '0;
    g.gnt[r] = 1'b1;
    g.j   = '0;
    g.k   = '0;
    if (!bad) begin
      g.j[idx] = j;
      g.k[idx] = k;
    end
    g.gap = gap;
    d.id  = IDXW'(r);
    d.rd  = bad ? 1'b0 : rd;
    d.err = bad;
    gq.push_back(g);
    dq.push_back(d);
  endtask

  task automatic set_op(input int r, input bit j, input bit k, input int idx);
    bus.req_j[r] = j;
    bus.req_k[r] = k;
    bus.req_idx[r*IDXW +: IDXW] = IDXW'(idx);
  endtask

  // Requesters drop REQ after their grant; keep_bit stays up for keep_n extra grants
  task automatic drain(input int budget, input int keep_bit, input int keep_n);
    int n;
    int kn;
    n  = 0;
    kn = keep_n;
    while (bus.req != '0) begin
      @(posedge clk);
      #1;
      n++;
      for (int r = 0; r < int'(NREQ); r++) begin
        if (bus.gnt[r]) begin
          if (r == keep_bit && kn > 0) kn--;
          else bus.req[r] = 1'b0;
        end
      end
      if (n > budget) begin
        chk("drain_timeout", 32'(n), 32'(budget));
        bus.req = '0;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a completion
  int last_g = 0;
  bit prev_done = 1'b0;
  logic [IDXW-1:0] held_id = '0;
  logic held_rd = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done === 1'b1) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          dexp_t d;
          d = dq.pop_front();
          chk("done_id", 32'(bus.done_id), 32'(d.id));
          chk("rd_q", 32'(bus.rd_q), 32'(d.rd));
          chk("err", 32'(bus.err), 32'(d.err));
          chk("done_latency", 32'(cyc - last_g), 32'(2));
        end
        held_id = bus.done_id;
        held_rd = bus.rd_q;
      end else if (prev_done) begin
        chk("err_clear", 32'(bus.err), 32'(0));
        chk("done_id_hold", 32'(bus.done_id), 32'(held_id));
        chk("rd_q_hold", 32'(bus.rd_q), 32'(held_rd));
      end
      prev_done = (bus.done === 1'b1);

      if (bus.gnt !== '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'(bus.gnt), 32'(0));
        end else begin
          gexp_t g;
          g = gq.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(g.gnt));
          chk("j_out", 32'(bus.j_out), 32'(g.j));
          chk("k_out", 32'(bus.k_out), 32'(g.k));
          if (g.gap != 0) chk("gnt_spacing", 32'(cyc - last_g), 32'(g.gap));
        end
        last_g = cyc;
      end else begin
        chk("idle_jk", 32'({bus.j_out, bus.k_out}), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req     = '0;
    bus.req_j   = '0;
    bus.req_k   = '0;
    bus.req_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_jk", 32'({bus.j_out, bus.k_out}), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    chk("rst_rd_q", 32'(bus.rd_q), 32'(0));
    chk("rst_done_id", 32'(bus.done_id), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Set bit 5 then toggle it back (pointer 0 -> 2)
    set_op(1, 1'b1, 1'b0, 5); expect_op(1, 1'b1, 1'b0, 5, 0, 1'b1);
    bus.req = 4'b0010; drain(20, -1, 0);
    set_op(1, 1'b1, 1'b1, 5); expect_op(1, 1'b1, 1'b1, 5, 0, 1'b0);
    bus.req = 4'b0010; drain(20, -1, 0);
    // Set bit 2, then a no-op on it reports the prior Q (pointer -> 0)
    set_op(2, 1'b1, 1'b0, 2); expect_op(2, 1'b1, 1'b0, 2, 0, 1'b1);
    bus.req = 4'b0100; drain(20, -1, 0);
    set_op(3, 1'b0, 1'b0, 2); expect_op(3, 1'b0, 1'b0, 2, 0, 1'b1);
    bus.req = 4'b1000; drain(20, -1, 0);
    chk("noop_bank", 32'(bank), 32'(6'h04));

    // Reset asserted during APPLY abandons the operation
    set_op(0, 1'b1, 1'b0, 0);
    bus.req = 4'b0001;
    begin
      int n;
      n = 0;
      while (bus.gnt[0] !== 1'b1 && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("pre_rst_gnt", 32'(bus.gnt), 32'(4'b0001));
      chk("pre_rst_j", 32'(bus.j_out), 32'(6'h01));
    end
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'(0));
    chk("midrst_jk", 32'({bus.j_out, bus.k_out}), 32'(0));
    chk("midrst_done", 32'(bus.done), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_bank", 32'(bank), 32'(6'h04));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full contention from pointer 0: grants 0,1,2,3, three cycles apart
    for (int r = 0; r < 4; r++) begin
      set_op(r, 1'b1, 1'b0, r);
      expect_op(r, 1'b1, 1'b0, r, (r == 0) ? 0 : 3, 1'b1);
    end
    bus.req = 4'b1111; drain(60, -1, 0);
    chk("contention_bank", 32'(bank), 32'(6'h0F));

`ifdef JK_ARB_PRIO0_EN
    // Requester 0 held for three grants beats everyone, then 1,2,3 follow
    set_op(0, 1'b1, 1'b1, 0);
    expect_op(0, 1'b1, 1'b1, 0, 0, 1'b0);
    expect_op(0, 1'b1, 1'b1, 0, 3, 1'b1);
    expect_op(0, 1'b1, 1'b1, 0, 3, 1'b0);
    for (int r = 1; r < 4; r++) expect_op(r, 1'b1, 1'b0, r, 3, 1'b1);
    bus.req = 4'b1111; drain(80, 0, 2);
`endif

    // Back-to-back: requester 2 held for four toggles of bit 4
    set_op(2, 1'b1, 1'b1, 4);
    expect_op(2, 1'b1, 1'b1, 4, 0, 1'b1);
    expect_op(2, 1'b1, 1'b1, 4, 3, 1'b0);
    expect_op(2, 1'b1, 1'b1, 4, 3, 1'b1);
    expect_op(2, 1'b1, 1'b1, 4, 3, 1'b0);
    bus.req = 4'b0100; drain(60, 2, 3);
    // Grant to 3 wraps the pointer to 0, so 0 then 1 win next
    set_op(3, 1'b1, 1'b0, 1); expect_op(3, 1'b1, 1'b0, 1, 0, 1'b1);
    bus.req = 4'b1000; drain(20, -1, 0);
    set_op(0, 1'b0, 1'b1, 0); expect_op(0, 1'b0, 1'b1, 0, 0, 1'b0);
    set_op(1, 1'b0, 1'b1, 1); expect_op(1, 1'b0, 1'b1, 1, 3, 1'b0);
    bus.req = 4'b0011; drain(40, -1, 0);

    // Out-of-range targets: granted, no J/K, ERR with RD_Q=0
    set_op(1, 1'b1, 1'b1, 7); expect_op(1, 1'b1, 1'b1, 7, 0, 1'b0);
    bus.req = 4'b0010; drain(20, -1, 0);
    set_op(2, 1'b1, 1'b0, 6); expect_op(2, 1'b1, 1'b0, 6, 0, 1'b0);
    bus.req = 4'b0100; drain(20, -1, 0);
    chk("bank_final", 32'(bank), 32'(6'h0C));

    chk("gq_empty", 32'(gq.size()), 32'(0));
    chk("dq_empty", 32'(dq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
